// File: rtl/input_fetcher_pkg.sv
// Shared definitions for the activation input fetcher: default widths,
// output FIFO depth, FSM state encoding and a small pointer helper.
package input_fetcher_pkg;

    localparam int DWIDTH_DEF = 12;
    localparam int AWIDTH_DEF = 10;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Circular pointer step for a FIFO whose depth is not a power of two.
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/input_fetcher_if.sv
// Command, buffer-port and output-stream signals of the input fetcher,
// seen from the fetcher (master) and from its environment (slave).
interface input_fetcher_if #(
    parameter int DWIDTH = 12,
    parameter int AWIDTH = 10
);

    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   length;
    logic              skip_zero;
    logic              busy;
    logic              done;

    logic [AWIDTH-1:0] mem_addr;
    logic              mem_ce;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_q;

    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic [AWIDTH-1:0] out_idx;

    modport master (
        input  start, base_addr, length, skip_zero, mem_q, out_ready,
        output busy, done, mem_addr, mem_ce, mem_we, out_valid, out_data, out_idx
    );

    modport slave (
        output start, base_addr, length, skip_zero, mem_q, out_ready,
        input  busy, done, mem_addr, mem_ce, mem_we, out_valid, out_data, out_idx
    );

endinterface

// File: rtl/input_fetcher_fetch_fifo.sv
// Three-entry first-in first-out buffer of {data, idx} pairs; push and pop
// may happen in the same cycle.
module fetch_fifo
    import input_fetcher_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic [AWIDTH-1:0] push_idx,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [DWIDTH-1:0] head_data,
    output logic [AWIDTH-1:0] head_idx
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [DWIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [AWIDTH-1:0] idx_mem  [FIFO_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        count_r;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count_r != 2'd0);
    assign do_push = push && ((count_r != FULL) || do_pop);

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_r <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                idx_mem[i]  <= '0;
            end
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                idx_mem[wr_ptr]  <= push_idx;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != 2'd0);
    assign head_data  = data_mem[rd_ptr];
    assign head_idx   = idx_mem[rd_ptr];

endmodule

// File: rtl/input_fetcher.sv
// Sweeps an address window of the activation buffer, optionally drops zero
// words, and streams (value, offset) pairs through a credit-managed FIFO.
module input_fetcher
    import input_fetcher_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input_fetcher_if.master bus
);

    localparam logic [AWIDTH:0] ONE   = (AWIDTH + 1)'(1);
    localparam logic [2:0]      DEPTH = 3'(FIFO_DEPTH);

    state_t            state;
    logic [AWIDTH-1:0] base_r;
    logic [AWIDTH-1:0] tag;
    logic [AWIDTH:0]   len_r;
    logic [AWIDTH:0]   offset;
    logic              skip_r;
    logic              inflight;
    logic              busy_r;
    logic              done_r;

    logic [1:0]        fifo_count;
    logic [1:0]        count_next;
    logic              issue;
    logic              last_issue;
    logic              capture;
    logic              pop;
    logic              head_valid;
    logic [DWIDTH-1:0] head_data;
    logic [AWIDTH-1:0] head_idx;

    // A read is issued only when the FIFO is guaranteed room for its data,
    // using registered occupancy so out_ready never reaches mem_ce.
    assign issue      = (state == RUN) && (({1'b0, fifo_count} + {2'b00, inflight}) < DEPTH);
    assign last_issue = issue && (offset == len_r - ONE);
    assign capture    = inflight && !(skip_r && (bus.mem_q == '0));
    assign pop        = head_valid && bus.out_ready;
    assign count_next = fifo_count + {1'b0, capture} - {1'b0, pop};

    fetch_fifo #(
        .DWIDTH(DWIDTH),
        .AWIDTH(AWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (bus.mem_q),
        .push_idx  (tag),
        .pop       (pop),
        .count     (fifo_count),
        .head_valid(head_valid),
        .head_data (head_data),
        .head_idx  (head_idx)
    );

    // Drain exits on the post-edge occupancy, so done lands the cycle
    // right after the last word leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_r   <= '0;
            len_r    <= '0;
            skip_r   <= 1'b0;
            offset   <= '0;
            tag      <= '0;
            inflight <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            inflight <= issue;
            if (issue) begin
                tag    <= offset[AWIDTH-1:0];
                offset <= offset + ONE;
            end
            case (state)
                IDLE: begin
                    if (bus.start && !done_r) begin
                        base_r <= bus.base_addr;
                        len_r  <= bus.length;
                        skip_r <= bus.skip_zero;
                        offset <= '0;
                        busy_r <= 1'b1;
                        state  <= (bus.length == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == 2'd0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = base_r + offset[AWIDTH-1:0];
    assign bus.mem_ce    = issue;
    assign bus.mem_we    = 1'b0;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_data;
    assign bus.out_idx   = head_idx;

endmodule

// File: tb/tb_input_fetcher.sv
// Directed and randomized sweeps of input_fetcher against a buffer model
// and a window/skip reference list built from the sweep parameters.
module tb_input_fetcher;

    localparam int DW = 12;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_fetcher_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    input_fetcher #(
        .DWIDTH(DW),
        .AWIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0]    mem [0:1023];
    logic [DW+AW-1:0] got_q[$];
    logic [DW+AW-1:0] exp_q[$];
    logic [AW-1:0]    addr_q[$];
    int rd_hits [0:1023];

    int cyc = 0;
    int done_cnt, done_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
    int ce_cnt, issued, accepted, max_occ, start_cyc;
    int ready_mode;
    int total  = 0;
    int passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer port with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_ce) bus.mem_q <= mem[bus.mem_addr];
    end

    // Observes the DUT mid-cycle; occupancy counts words read but not yet taken.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_ce) begin
                ce_cnt <= ce_cnt + 1;
                issued <= issued + 1;
                addr_q.push_back(bus.mem_addr);
                rd_hits[bus.mem_addr] <= rd_hits[bus.mem_addr] + 1;
            end
            if (issued + int'(bus.mem_ce) - accepted > max_occ)
                max_occ <= issued + int'(bus.mem_ce) - accepted;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.out_data, bus.out_idx});
                accepted <= accepted + 1;
                if (first_acc_cyc < 0) first_acc_cyc <= cyc;
                last_acc_cyc <= cyc;
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    task automatic clear_logs();
        got_q.delete();
        addr_q.delete();
        for (int i = 0; i < 1024; i++) rd_hits[i] = 0;
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        first_acc_cyc = -1; last_acc_cyc = -1;
        ce_cnt = 0; issued = 0; accepted = 0; max_occ = 0;
    endtask

    task automatic apply_stimulus(input int base, input int len, input bit skip);
        clear_logs();
        bus.base_addr = AW'(base);
        bus.length    = (AW + 1)'(len);
        bus.skip_zero = skip;
        bus.start     = 1'b1;
        start_cyc     = cyc;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        check_output({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
        check_output({tag, "_done_once"}, done_cnt, 1);
    endtask

    // Reference: every window offset in order, minus zero words when skipping.
    task automatic build_expected(input int base, input int len, input bit skip);
        logic [DW-1:0] v;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            v = mem[(base + i) % 1024];
            if (!(skip && v == '0)) exp_q.push_back({v, AW'(i)});
        end
    endtask

    task automatic compare_stream(input string tag);
        int nbad;
        int first_bad;
        nbad = 0;
        first_bad = -1;
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            $display("[TB] %s first bad word at %0d", tag, first_bad);
        check_output({tag, "_bad_words"}, nbad, 0);
    endtask

    task automatic run_dense(input string tag);
        for (int i = 0; i < 8; i++) mem[16 + i] = DW'(i + 1);
        ready_mode = 0;
        apply_stimulus(16, 8, 1'b0);
        check_output({tag, "_busy"}, bus.busy, 1);
        wait_done(tag, 40);
        build_expected(16, 8, 1'b0);
        compare_stream(tag);
        check_output({tag, "_latency"}, first_valid_cyc - start_cyc, 3);
        check_output({tag, "_back_to_back"}, last_acc_cyc - first_acc_cyc, 7);
        check_output({tag, "_done_delay"}, done_cyc - last_acc_cyc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] wrap_addr [4];
        int base, len, nbad;
        bit skip;

        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.skip_zero = 1'b0; bus.out_ready = 1'b0;
        ready_mode = 2;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_logs();
        tick(); tick(); tick();
        rst = 1'b0;
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_done", bus.done, 0);
        check_output("rst_mem_ce", bus.mem_ce, 0);
        check_output("rst_mem_addr", bus.mem_addr, 0);
        check_output("rst_mem_we", bus.mem_we, 0);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out_data", bus.out_data, 0);
        check_output("rst_out_idx", bus.out_idx, 0);
        tick();

        $display("[TB] dense sweep");
        run_dense("dense");

        $display("[TB] zero skip");
        for (int i = 0; i < 6; i++) mem[256 + i] = '0;
        mem[257] = DW'(5);
        mem[260] = DW'(7);
        ready_mode = 0;
        apply_stimulus(256, 6, 1'b1);
        wait_done("skip1", 40);
        build_expected(256, 6, 1'b1);
        check_output("skip1_model_size", exp_q.size(), 2);
        compare_stream("skip1");
        apply_stimulus(256, 6, 1'b0);
        wait_done("skip0", 40);
        build_expected(256, 6, 1'b0);
        compare_stream("skip0");

        $display("[TB] wrap");
        wrap_addr[0] = 10'h3FE; wrap_addr[1] = 10'h3FF;
        wrap_addr[2] = 10'h000; wrap_addr[3] = 10'h001;
        for (int i = 0; i < 4; i++) mem[wrap_addr[i]] = DW'($urandom_range(1, 4095));
        apply_stimulus(10'h3FE, 4, 1'b0);
        wait_done("wrap", 40);
        check_output("wrap_reads", addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            check_output($sformatf("wrap_addr%0d", i), addr_q[i], wrap_addr[i]);
        build_expected(10'h3FE, 4, 1'b0);
        compare_stream("wrap");

        $display("[TB] backpressure with ignored start");
        for (int i = 0; i < 16; i++) mem[128 + i] = DW'($urandom_range(0, 4095));
        ready_mode = 1;
        apply_stimulus(128, 16, 1'b0);
        tick(); tick(); tick();
        bus.base_addr = '0; bus.length = 11'd5; bus.skip_zero = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        ready_mode = 2;
        repeat (10) tick();
        check_output("bp_stall_ce", bus.mem_ce, 0);
        check_output("bp_stall_valid", bus.out_valid, 1);
        ready_mode = 1;
        wait_done("bp", 200);
        check_output("bp_max_occupancy", 32'(max_occ <= 3), 32'd1);
        check_output("bp_read_count", ce_cnt, 16);
        build_expected(128, 16, 1'b0);
        compare_stream("bp");

        $display("[TB] zero length");
        ready_mode = 0;
        apply_stimulus(10'h055, 0, 1'b0);
        wait_done("len0", 20);
        check_output("len0_done_delay", done_cyc - start_cyc, 2);
        check_output("len0_no_reads", ce_cnt, 0);
        check_output("len0_no_valid", first_valid_cyc, -1);

        $display("[TB] random sweeps");
        for (int n = 0; n < 4; n++) begin
            base = $urandom_range(0, 1023);
            len  = $urandom_range(1, 40);
            skip = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                mem[(base + i) % 1024] = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(1, 4095));
            ready_mode = 1;
            apply_stimulus(base, len, skip);
            wait_done($sformatf("rnd%0d", n), 400);
            build_expected(base, len, skip);
            compare_stream($sformatf("rnd%0d", n));
        end

        $display("[TB] full window");
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom_range(0, 4095));
        ready_mode = 0;
        apply_stimulus(0, 1024, 1'b0);
        wait_done("full", 1200);
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (rd_hits[i] != 1) nbad++;
        check_output("full_addr_once", nbad, 0);
        build_expected(0, 1024, 1'b0);
        compare_stream("full");

        $display("[TB] reset mid-run");
        for (int i = 0; i < 16; i++) mem[512 + i] = DW'($urandom_range(1, 4095));
        ready_mode = 2;
        apply_stimulus(512, 16, 1'b0);
        tick(); tick(); tick();
        check_output("midrst_buffered", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        check_output("midrst_busy", bus.busy, 0);
        check_output("midrst_valid", bus.out_valid, 0);
        check_output("midrst_done", bus.done, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        check_output("midrst_no_done", done_cnt, 0);
        check_output("midrst_idle_ce", bus.mem_ce, 0);
        check_output("midrst_idle_valid", bus.out_valid, 0);
        run_dense("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
